// File: rtl/cardinal_nic.sv
// Cardinal NIC: processor-visible register interface bridging a router port.
// One 64-bit buffer with a full flag per direction; bit 0 of the output buffer is the VC bit.
module cardinal_nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:1]  addr,
  input  logic [0:63] d_in,
  output logic [0:63] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [0:63] net_di,
  output logic        net_so,
  input  logic        net_ro,
  output logic [0:63] net_do,
  input  logic        net_polarity
);

  logic [0:63] r_ibuf;
  logic [0:63] r_obuf;
  logic        r_ist;
  logic        r_ost;

  logic w_rd;
  logic w_wr;
  logic w_recv;
  logic w_send;
  logic w_ibuf_rd;
  logic w_obuf_wr;

  assign w_rd      = nicEn & ~nicWrEn;
  assign w_wr      = nicEn & nicWrEn;
  assign w_recv    = net_si & ~r_ist;
  assign w_send    = r_ost & net_ro & (net_polarity == r_obuf[0]);
  assign w_ibuf_rd = w_rd & (addr == 2'b00) & r_ist;
  // Writes while the output buffer is full are dropped, even if a send retires it this edge.
  assign w_obuf_wr = w_wr & (addr == 2'b10) & ~r_ost;

  assign net_ri = ~r_ist;
  assign net_so = w_send;
  assign net_do = r_obuf;

  always_comb begin
    d_out = '0;
    if (w_rd) begin
      case (addr)
        2'b00:   d_out = r_ibuf;
        2'b01:   d_out = {63'b0, r_ist};
        2'b10:   d_out = r_obuf;
        default: d_out = {63'b0, r_ost};
      endcase
    end
  end

  // Receive and read-clear are mutually exclusive (one needs ist=0, the other ist=1).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ibuf <= '0;
      r_ist  <= 1'b0;
    end else if (w_recv) begin
      r_ibuf <= net_di;
      r_ist  <= 1'b1;
    end else if (w_ibuf_rd) begin
      r_ist  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_obuf <= '0;
      r_ost  <= 1'b0;
    end else if (w_obuf_wr) begin
      r_obuf <= d_in;
      r_ost  <= 1'b1;
    end else if (w_send) begin
      r_ost  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: buffer-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int n_cmp = 0;
  int n_err = 0;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  // Reference model: contents of each buffer and whether it holds a packet.
  logic [0:63] m_ibuf;
  logic [0:63] m_obuf;
  logic        m_ifull;
  logic        m_ofull;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ibuf  <= '0;
      m_obuf  <= '0;
      m_ifull <= 1'b0;
      m_ofull <= 1'b0;
    end else begin
      if (!m_ifull && net_si) begin
        m_ibuf  <= net_di;
        m_ifull <= 1'b1;
      end else if (m_ifull && nicEn && !nicWrEn && addr == 2'b00) begin
        m_ifull <= 1'b0;
      end
      if (!m_ofull && nicEn && nicWrEn && addr == 2'b10) begin
        m_obuf  <= d_in;
        m_ofull <= 1'b1;
      end else if (m_ofull && net_ro && net_polarity == m_obuf[0]) begin
        m_ofull <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the rising edge.
  always @(negedge clk) begin
    logic [63:0] exp_dout;
    exp_dout = '0;
    if (nicEn && !nicWrEn) begin
      if (addr == 2'b00)      exp_dout = m_ibuf;
      else if (addr == 2'b01) exp_dout = {63'b0, m_ifull};
      else if (addr == 2'b10) exp_dout = m_obuf;
      else                    exp_dout = {63'b0, m_ofull};
    end
    chk("model_net_ri", {63'b0, net_ri}, {63'b0, !m_ifull});
    chk("model_net_so", {63'b0, net_so},
        {63'b0, m_ofull && net_ro && (net_polarity == m_obuf[0])});
    chk("model_net_do", net_do, m_obuf);
    chk("model_d_out", d_out, exp_dout);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0; net_si = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] v);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
  endtask

  localparam logic [63:0] P1 = 64'hA5A5_0000_1234_5678;
  localparam logic [63:0] P2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] P3 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] O1 = 64'h8000_0000_0000_00FF;
  localparam logic [63:0] O2 = 64'h0123_4567_89AB_CDEF;

  initial begin
    reset = 1'b0; idle(); net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    #2;
    rd(2'b00);
    #1;
    chk("rst_net_ri", {63'b0, net_ri}, 64'h1);
    chk("rst_net_so", {63'b0, net_so}, 64'h0);
    chk("rst_net_do", net_do, 64'h0);
    chk("rst_d_out", d_out, 64'h0);
    tick(); tick();
    reset = 1'b1; idle();
    tick();

    // Receive, status read, data read, release.
    net_si = 1'b1; net_di = P1;
    tick();
    net_si = 1'b0;
    chk("rx_ri_low", {63'b0, net_ri}, 64'h0);
    rd(2'b01); #1;
    chk("rx_ist", d_out, 64'h1);
    rd(2'b00); #1;
    chk("rx_data", d_out, P1);
    tick();
    idle(); #1;
    chk("rx_ri_back", {63'b0, net_ri}, 64'h1);

    // Read of empty ibuf leaves status clear.
    rd(2'b00); tick();
    rd(2'b01); #1;
    chk("rd_empty_ist", d_out, 64'h0);

    // Backpressure: second packet ignored.
    idle(); net_si = 1'b1; net_di = P2; tick();
    net_di = P3; tick();
    net_si = 1'b0;
    chk("bp_ri", {63'b0, net_ri}, 64'h0);
    rd(2'b00); #1;
    chk("bp_ibuf", d_out, P2);
    tick(); idle();

    // Send gated by polarity.
    net_ro = 1'b1; net_polarity = 1'b0;
    wr(2'b10, O1); tick(); idle();
    chk("tx_do", net_do, O1);
    chk("tx_so_wait", {63'b0, net_so}, 64'h0);
    tick(); tick();
    chk("tx_so_wait2", {63'b0, net_so}, 64'h0);
    net_polarity = 1'b1; #1;
    chk("tx_so_go", {63'b0, net_so}, 64'h1);
    tick();
    rd(2'b11); #1;
    chk("tx_ost_clr", d_out, 64'h0);
    chk("tx_so_done", {63'b0, net_so}, 64'h0);

    // Dropped write while full, including on the completing edge.
    idle(); net_ro = 1'b0; net_polarity = 1'b0;
    wr(2'b10, O2); tick();
    wr(2'b10, 64'h1); tick();
    chk("drop_do", net_do, O2);
    rd(2'b11); #1;
    chk("drop_ost", d_out, 64'h1);
    net_ro = 1'b1;
    wr(2'b10, 64'h2); #1;
    chk("drop_so", {63'b0, net_so}, 64'h1);
    tick();
    chk("drop_same_edge_do", net_do, O2);
    rd(2'b11); #1;
    chk("drop_same_edge_ost", d_out, 64'h0);

    // Writes to other addresses have no effect.
    wr(2'b00, 64'hFFFF); tick();
    wr(2'b01, 64'h1); tick();
    wr(2'b11, 64'h1); tick();
    rd(2'b01); #1;
    chk("wr_other_ist", d_out, 64'h0);
    rd(2'b00); #1;
    chk("wr_other_ibuf", d_out, P2);

    // Concurrent receive and write.
    idle(); net_ro = 1'b0;
    net_si = 1'b1; net_di = P3; wr(2'b10, O1); tick();
    idle();
    rd(2'b01); #1;
    chk("conc_ist", d_out, 64'h1);
    rd(2'b11); #1;
    chk("conc_ost", d_out, 64'h1);

    // Asynchronous reset between edges.
    idle(); #2;
    reset = 1'b0; #1;
    chk("arst_ri", {63'b0, net_ri}, 64'h1);
    chk("arst_so", {63'b0, net_so}, 64'h0);
    chk("arst_do", net_do, 64'h0);
    tick();
    reset = 1'b1; tick();
    rd(2'b00); #1;
    chk("arst_ibuf", d_out, 64'h0);
    rd(2'b10); #1;
    chk("arst_obuf", d_out, 64'h0);

    // Mixed traffic checked by the model each cycle.
    for (int i = 0; i < 300; i++) begin
      nicEn        = 1'($urandom);
      nicWrEn      = 1'($urandom);
      addr         = 2'($urandom);
      d_in         = {$urandom, $urandom};
      net_si       = 1'($urandom);
      net_di       = {$urandom, $urandom};
      net_ro       = 1'($urandom);
      net_polarity = 1'($urandom);
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cardinal_nic.md
CARDINAL_NIC -- requirements
Module: cardinal_nic

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-003 SHALL have port: addr  input  2 [0:1]  processor-side register select.
REQ-004 SHALL have port: d_in  input  64 [0:63]  write data from processor.
REQ-005 SHALL have port: d_out  output  64 [0:63]  read data to processor.
REQ-006 SHALL have port: nicEn  input  1  access enable.
REQ-007 SHALL have port: nicWrEn  input  1  1 = write, 0 = read (valid only with nicEn).
REQ-008 SHALL have port: net_si  input  1  router send-in valid.
REQ-009 SHALL have port: net_ri  output  1  NIC ready to accept packet from router.
REQ-010 SHALL have port: net_di  input  64 [0:63]  packet from router.
REQ-011 SHALL have port: net_so  output  1  NIC send-out valid to router.
REQ-012 SHALL have port: net_ro  input  1  router ready to accept packet from NIC.
REQ-013 SHALL have port: net_do  output  64 [0:63]  packet to router.
REQ-014 SHALL have port: net_polarity  input  1  router even/odd cycle indicator.

Function
REQ-015 SHALL hold four register addresses: 00 input buffer (ibuf, 64b), 01 input status (ist, 1b), 10 output buffer (obuf, 64b), 11 output status (ost, 1b); status 1 = full.
REQ-016 SHALL drive d_out combinationally when nicEn=1 and nicWrEn=0: addr 00 -> ibuf; 01 -> {63'b0, ist}; 10 -> obuf; 11 -> {63'b0, ost}; otherwise d_out = 0.
REQ-017 SHALL drive net_ri = ~ist combinationally.
REQ-018 SHALL, on a rising edge with net_si=1 and net_ri=1, load ibuf <= net_di and set ist <= 1; net_si with net_ri=0 SHALL be ignored with ibuf unchanged.
REQ-019 SHALL, on a rising edge with a processor read of addr 00 (nicEn=1, nicWrEn=0) while ist=1, clear ist <= 0; ibuf holds its value.
REQ-020 SHALL ignore a read of addr 00 while ist=0, leaving ist at 0.
REQ-021 SHALL, on a rising edge with a processor write to addr 10 while ost=0, load obuf <= d_in and set ost <= 1.
REQ-022 SHALL drop a write to addr 10 while ost=1; obuf and ost remain unchanged, including when a send completes on the same edge.
REQ-023 SHALL ignore writes to addr 00, 01 and 11.
REQ-024 SHALL drive net_do = obuf at all times.
REQ-025 SHALL assert net_so combinationally only when ost=1, net_ro=1 and net_polarity == obuf[0] (VC bit); the send completes in that cycle and ost SHALL be cleared on the same rising edge.
REQ-026 SHALL hold net_so=0 while ost=1 and the polarity mismatches or net_ro=0; the packet is retained until the conditions are met (no timeout).
REQ-027 SHALL keep the input and output channels independent; simultaneous receive, send, processor read and processor write in one cycle are all legal and each behaves per REQ-018..025.
REQ-028 SHALL yield a minimum processor-write-to-net_so latency of 1 cycle, and a minimum net_si-to-ist-visible latency of 1 cycle.

Reset
REQ-029 SHALL, while reset=0, force ibuf=0, obuf=0, ist=0 and ost=0, giving net_ri=1, net_so=0, net_do=0 and d_out=0; this applies asynchronously, including mid-transfer.
REQ-030 SHALL resume normal operation on the first rising edge after reset returns to 1.

Verification
REQ-031 SHALL cover receive: ist=0, net_si=1, net_di=64'hA5A5_0000_1234_5678 -> next cycle net_ri=0, read addr 01 gives 64'h1, read addr 00 gives the packet, following cycle ist=0 and net_ri=1.
REQ-032 SHALL cover backpressure: ist=1, net_si=1 with a new packet -> ibuf unchanged, net_ri stays 0.
REQ-033 SHALL cover send with polarity: write addr 10 = 64'h8000_0000_0000_00FF (VC=1), net_ro=1 -> net_so=0 while net_polarity=0, net_so=1 on the first cycle net_polarity=1, and ost=0 after that edge.
REQ-034 SHALL cover dropped write: ost=1, write addr 10 = 64'h1 -> obuf keeps its prior value, and read addr 11 gives 64'h1.
REQ-035 SHALL cover reset mid-operation: ist=1 and ost=1, reset driven low between clock edges -> immediately net_ri=1, net_so=0, net_do=0, and reads return 0 after release.
REQ-036 SHALL cover a concurrent cycle: net_si=1 (ist=0), processor write addr 10 (ost=0) and net_ro=0 in the same cycle -> both ist=1 and ost=1 after the edge.
